mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 41 ++++
 rtl/ls_align.sv | 55 +++++
 rtl/mem_stage_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM encoding, funct3 codes
// and the access-legality rule.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unsupported size codes plus halfword/word accesses that straddle their natural alignment.
    function automatic logic access_illegal(input logic is_store, input logic [2:0] funct3,
                                            input logic [1:0] offset);
        logic bad;
        if (is_store) begin
            bad = !((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
        end else begin
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        if ((funct3[1:0] == 2'b01) && offset[0]) begin
            bad = 1'b1;
        end else if ((funct3[1:0] == 2'b10) && (offset != 2'b00)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

endpackage

// File: rtl/ls_align.sv
// Byte-lane enables, store-data replication and load-data lane select/extension.
module ls_align
    import mem_stage_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata >> {offset, 3'b000};

    // Store side: enables and replicated data chosen by access size.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load side: lane already shifted down to bit 0, then sign- or zero-extended.
    always_comb begin
        rdata_ext = 32'd0;
        case (funct3)
            F3_LB:   rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_LH:   rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   rdata_ext = shifted_s;
            F3_LBU:  rdata_ext = {24'd0, shifted_s[7:0]};
            F3_LHU:  rdata_ext = {16'd0, shifted_s[15:0]};
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns M-stage loads/stores into a req/ack bus access,
// stalling the pipeline until the access completes or times out.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MemFaultM,
    output logic        BusErrM
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_r;
    logic [7:0]  cnt_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r;
    logic        is_load_r;

    logic        is_store_s;
    logic        is_load_s;
    logic        pending_s;
    logic        illegal_s;
    logic        start_s;
    logic        timeout_s;
    logic [2:0]  align_f3_s;
    logic [1:0]  align_off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;
    logic [31:0] rdata_ext_s;

    assign is_store_s = MemWriteM;
    assign is_load_s  = (ResultSrcM == RESULT_SRC_LOAD) && !MemWriteM;
    assign pending_s  = is_store_s || is_load_s;
    assign illegal_s  = access_illegal(is_store_s, funct3M, ALUResultM[1:0]);
    assign start_s    = (state_r == ST_IDLE) && pending_s && !illegal_s;
    assign timeout_s  = !mem_ack && (cnt_r == TIMEOUT_LAST);

    // Stall and fault must react in the same cycle the instruction shows up, so they
    // are decoded from state and inputs; reset masks them so a held load cannot stall.
    assign StallM    = !reset && (start_s || (state_r == ST_BUSY));
    assign MemFaultM = !reset && (state_r == ST_IDLE) && pending_s && illegal_s;

    // The shared aligner serves the live instruction in IDLE and the captured one afterwards.
    assign align_f3_s  = (state_r == ST_IDLE) ? funct3M : funct3_r;
    assign align_off_s = (state_r == ST_IDLE) ? ALUResultM[1:0] : offset_r;

    ls_align u_ls_align (
        .funct3    (align_f3_s),
        .offset    (align_off_s),
        .wdata     (WriteDataM),
        .rdata     (mem_rdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .rdata_ext (rdata_ext_s)
    );

    // Access FSM with registered bus-side outputs, load result and bus-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            funct3_r  <= 3'd0;
            offset_r  <= 2'd0;
            is_load_r <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            ReadDataM <= 32'd0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ReadDataM <= 32'd0;
                    if (start_s) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= 8'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store_s;
                        mem_addr  <= {ALUResultM[31:2], 2'b00};
                        mem_wdata <= wdata_rep_s;
                        mem_be    <= be_s;
                        funct3_r  <= funct3M;
                        offset_r  <= ALUResultM[1:0];
                        is_load_r <= is_load_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // An ack in the timeout cycle wins: it is checked first.
                    if (mem_ack) begin
                        state_r   <= ST_DONE;
                        mem_req   <= 1'b0;
                        ReadDataM <= is_load_r ? rdata_ext_s : 32'd0;
                    end else if (timeout_s) begin
                        state_r   <= ST_DONE;
                        mem_req   <= 1'b0;
                        ReadDataM <= 32'd0;
                        BusErrM   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    ReadDataM <= 32'd0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req   <= 1'b0;
                    ReadDataM <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a default-timeout instance for the main
// access tests and a TIMEOUT_CYCLES=4 instance for the bus-error tests.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        a_req, a_we, a_stall, a_fault, a_berr;
    logic [31:0] a_addr, a_wdata, a_rd;
    logic [3:0]  a_be;
    logic        b_req, b_we, b_stall, b_fault, b_berr;
    logic [31:0] b_addr, b_wdata, b_rd;
    logic [3:0]  b_be;

    logic        use_to;
    logic        o_req, o_we, o_stall, o_fault, o_berr;
    logic [31:0] o_addr, o_wdata, o_rd;
    logic [3:0]  o_be;

    assign o_req   = use_to ? b_req   : a_req;
    assign o_we    = use_to ? b_we    : a_we;
    assign o_stall = use_to ? b_stall : a_stall;
    assign o_fault = use_to ? b_fault : a_fault;
    assign o_berr  = use_to ? b_berr  : a_berr;
    assign o_addr  = use_to ? b_addr  : a_addr;
    assign o_wdata = use_to ? b_wdata : a_wdata;
    assign o_rd    = use_to ? b_rd    : a_rd;
    assign o_be    = use_to ? b_be    : a_be;

    mem_stage_ctrl dut (
        .clk(clk), .reset(reset), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
        .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_be(a_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .StallM(a_stall), .ReadDataM(a_rd),
        .MemFaultM(a_fault), .BusErrM(a_berr)
    );

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
        .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_be(b_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .StallM(b_stall), .ReadDataM(b_rd),
        .MemFaultM(b_fault), .BusErrM(b_berr)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          stall_n;
    int          fault_n;
    logic        req_seen;
    logic        finished;
    logic [31:0] done_rd;
    logic        done_berr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wd;
    logic [31:0] bus_addr;
    logic        bus_we;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic [1:0] rs, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3);
        ResultSrcM = rs;
        MemWriteM  = we;
        ALUResultM = addr;
        WriteDataM = wd;
        funct3M    = f3;
    endtask

    task automatic set_nop();
        set_instr(2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, 3'b000);
    endtask

    // Called 2 time units after a rising edge; ack_at is the 1-based BUSY cycle to ack in (0 = never).
    task automatic run_access(input int ack_at, input logic [31:0] rdata);
        int busy_n;
        busy_n   = 0;
        stall_n  = 0;
        fault_n  = 0;
        req_seen = 1'b0;
        finished = 1'b0;
        done_rd  = 32'h0;
        done_berr = 1'b0;
        mem_rdata = rdata;
        for (int cyc = 0; cyc < 400; cyc++) begin
            mem_ack = 1'b0;
            if (o_req) begin
                busy_n++;
                req_seen = 1'b1;
                bus_be   = o_be;
                bus_wd   = o_wdata;
                bus_addr = o_addr;
                bus_we   = o_we;
                if (busy_n == ack_at) mem_ack = 1'b1;
            end
            #1;
            if (o_fault) fault_n++;
            if (!o_stall) begin
                done_rd   = o_rd;
                done_berr = o_berr;
                finished  = 1'b1;
                break;
            end
            stall_n++;
            @(posedge clk);
            #2;
        end
        check_val("done_reached", 32'(finished), 32'd1);
        mem_ack = 1'b0;
        @(posedge clk);
        #2;
        set_nop();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_nop();
        mem_ack = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        use_to    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        set_instr(2'b01, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        repeat (2) @(posedge clk);
        #3;
        check_val("rst_req",   32'(o_req),   32'd0);
        check_val("rst_we",    32'(o_we),    32'd0);
        check_val("rst_addr",  o_addr,       32'd0);
        check_val("rst_wdata", o_wdata,      32'd0);
        check_val("rst_be",    32'(o_be),    32'd0);
        check_val("rst_rd",    o_rd,         32'd0);
        check_val("rst_stall", 32'(o_stall), 32'd0);
        check_val("rst_fault", 32'(o_fault), 32'd0);
        check_val("rst_berr",  32'(o_berr),  32'd0);
        set_nop();
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Non-memory instructions pass with no stall
        set_instr(2'b00, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        run_access(0, 32'h0);
        check_val("alu_stall", 32'(stall_n), 32'd0);
        check_val("alu_req",   32'(req_seen), 32'd0);
        set_instr(2'b10, 1'b0, 32'h0000_0101, 32'h0, 3'b001);
        run_access(0, 32'h0);
        check_val("jal_stall", 32'(stall_n), 32'd0);
        check_val("jal_fault", 32'(fault_n), 32'd0);

        // LW 0x100, ack in first BUSY cycle
        set_instr(2'b01, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        run_access(1, 32'hDEAD_BEEF);
        check_val("lw_stall", 32'(stall_n), 32'd2);
        check_val("lw_rd",    done_rd,      32'hDEAD_BEEF);
        check_val("lw_be",    32'(bus_be),  32'h0000_000F);
        check_val("lw_addr",  bus_addr,     32'h0000_0100);
        check_val("lw_we",    32'(bus_we),  32'd0);
        #1;
        check_val("lw_rd_after", o_rd, 32'd0);

        // SB 0x103, ack on the fifth BUSY cycle
        set_instr(2'b00, 1'b1, 32'h0000_0103, 32'h0000_00A5, 3'b000);
        run_access(5, 32'hFFFF_FFFF);
        check_val("sb_stall", 32'(stall_n), 32'd6);
        check_val("sb_be",    32'(bus_be),  32'h0000_0008);
        check_val("sb_wdata", bus_wd,       32'hA5A5_A5A5);
        check_val("sb_we",    32'(bus_we),  32'd1);
        check_val("sb_addr",  bus_addr,     32'h0000_0100);
        check_val("sb_rd",    done_rd,      32'd0);

        // Byte loads from lane 2
        set_instr(2'b01, 1'b0, 32'h0000_0102, 32'h0, 3'b000);
        run_access(2, 32'h0080_0000);
        check_val("lb_rd",    done_rd,      32'hFFFF_FF80);
        check_val("lb_be",    32'(bus_be),  32'h0000_0004);
        check_val("lb_stall", 32'(stall_n), 32'd3);
        set_instr(2'b01, 1'b0, 32'h0000_0102, 32'h0, 3'b100);
        run_access(1, 32'h0080_0000);
        check_val("lbu_rd",   done_rd,      32'h0000_0080);

        // Halfword store and loads on the upper half
        set_instr(2'b00, 1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001);
        run_access(1, 32'h0);
        check_val("sh_be",    32'(bus_be),  32'h0000_000C);
        check_val("sh_wdata", bus_wd,       32'hABCD_ABCD);
        set_instr(2'b01, 1'b0, 32'h0000_0202, 32'h0, 3'b001);
        run_access(1, 32'h8001_1234);
        check_val("lh_rd",    done_rd,      32'hFFFF_8001);
        set_instr(2'b01, 1'b0, 32'h0000_0202, 32'h0, 3'b101);
        run_access(1, 32'h8001_1234);
        check_val("lhu_rd",   done_rd,      32'h0000_8001);

        // Illegal accesses fault in IDLE without a request
        set_instr(2'b01, 1'b0, 32'h0000_0101, 32'h0, 3'b001);
        run_access(1, 32'h0);
        check_val("lh_mis_fault", 32'(fault_n),  32'd1);
        check_val("lh_mis_stall", 32'(stall_n),  32'd0);
        check_val("lh_mis_req",   32'(req_seen), 32'd0);
        #1;
        check_val("lh_mis_pulse", 32'(o_fault),  32'd0);
        check_val("lh_mis_req2",  32'(o_req),    32'd0);
        set_instr(2'b00, 1'b1, 32'h0000_0102, 32'h0, 3'b010);
        run_access(1, 32'h0);
        check_val("sw_mis_fault", 32'(fault_n),  32'd1);
        set_instr(2'b01, 1'b0, 32'h0000_0100, 32'h0, 3'b011);
        run_access(1, 32'h0);
        check_val("ld_f3_fault",  32'(fault_n),  32'd1);
        check_val("ld_f3_req",    32'(req_seen), 32'd0);

        // Timeout with TIMEOUT_CYCLES=4
        do_reset();
        use_to = 1'b1;
        set_instr(2'b01, 1'b0, 32'h0000_0200, 32'h0, 3'b010);
        run_access(0, 32'h1234_5678);
        check_val("to_stall", 32'(stall_n),   32'd5);
        check_val("to_berr",  32'(done_berr), 32'd1);
        check_val("to_rd",    done_rd,        32'd0);
        #1;
        check_val("to_berr_pulse", 32'(o_berr),  32'd0);
        check_val("to_idle_stall", 32'(o_stall), 32'd0);
        set_instr(2'b01, 1'b0, 32'h0000_0200, 32'h0, 3'b010);
        run_access(4, 32'hCAFE_F00D);
        check_val("ack_at_to_berr",  32'(done_berr), 32'd0);
        check_val("ack_at_to_rd",    done_rd,        32'hCAFE_F00D);
        check_val("ack_at_to_stall", 32'(stall_n),   32'd5);

        // Reset during the second BUSY cycle
        use_to = 1'b0;
        do_reset();
        set_instr(2'b01, 1'b0, 32'h0000_0300, 32'h0, 3'b010);
        repeat (2) @(posedge clk);
        #3;
        check_val("busy2_req", 32'(o_req), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_req",   32'(o_req),   32'd0);
        check_val("mid_rst_stall", 32'(o_stall), 32'd0);
        check_val("mid_rst_fault", 32'(o_fault), 32'd0);
        check_val("mid_rst_berr",  32'(o_berr),  32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_access(1, 32'h0BAD_F00D);
        check_val("post_rst_stall", 32'(stall_n), 32'd2);
        check_val("post_rst_rd",    done_rd,      32'h0BAD_F00D);
        check_val("post_rst_addr",  bus_addr,     32'h0000_0300);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
